// File: rtl/maxpool_stream_pkg.sv
// rtl/maxpool_stream_pkg.sv - shared pooling mode enum and accumulator width helper
package maxpool_stream_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  // Room for POOL*POOL full-width elements so the window sum never overflows.
  function automatic int accw(input int bits, input int pool);
    return 2 * bits + 2 * $clog2(pool);
  endfunction

endpackage

// File: rtl/maxpool_stream_combine.sv
// rtl/maxpool_stream_combine.sv - combinational per-element max/sum combine
module pool_combine
  import maxpool_stream_pkg::*;
#(
  parameter int BITS   = 8,
  parameter int POOL   = 2,
  parameter int SIGNED = 0,
  localparam int AW    = accw(BITS, POOL)
) (
  input  pool_mode_e          mode,
  input  logic                init,
  input  logic [AW-1:0]       acc,
  input  logic [2*BITS-1:0]   din,
  output logic [AW-1:0]       acc_next
);

  logic [AW-1:0] dinExt;
  logic          greater;

  // Entries always hold the extended element, so max compares at full width.
  always_comb begin
    if (SIGNED != 0) begin
      dinExt  = {{(AW-2*BITS){din[2*BITS-1]}}, din};
      greater = $signed(dinExt) > $signed(acc);
    end else begin
      dinExt  = {{(AW-2*BITS){1'b0}}, din};
      greater = dinExt > acc;
    end

    acc_next = acc;
    if (init) begin
      acc_next = dinExt;
    end else if (mode == POOL_AVG) begin
      acc_next = acc + dinExt;
    end else if (greater) begin
      acc_next = dinExt;
    end
  end

endmodule

// File: rtl/maxpool_stream.sv
// rtl/maxpool_stream.sv - streaming POOLxPOOL max/avg pooling over a DIMxDIM raster frame
module maxpool_stream
  import maxpool_stream_pkg::*;
#(
  parameter int BITS   = 8,
  parameter int DIM    = 32,
  parameter int POOL   = 2,
  parameter int SIGNED = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*BITS-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*BITS-1:0]   out_data,
  output logic                out_last
);

  localparam int W   = 2 * BITS;
  localparam int AW  = accw(BITS, POOL);
  localparam int PSH = $clog2(POOL);
  localparam int SH  = 2 * PSH;
  localparam int NE  = DIM / POOL;
  localparam int CW  = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int IW  = (NE > 1) ? $clog2(NE) : 1;

  logic [CW-1:0] row, col;
  pool_mode_e    modeLat, modeEff;
  logic [AW-1:0] partBuf [NE];
  logic [IW-1:0] idx;
  logic          inXfer, firstWin, lastWin, firstElem, lastCol, lastRow;
  logic [AW-1:0] accNext;
  logic [W-1:0]  result;

  assign in_ready  = !out_valid || out_ready;
  assign inXfer    = in_valid && in_ready;
  assign idx       = IW'(col >> PSH);
  assign firstWin  = (row[PSH-1:0] == '0) && (col[PSH-1:0] == '0);
  assign lastWin   = (&row[PSH-1:0]) && (&col[PSH-1:0]);
  assign firstElem = (row == '0) && (col == '0);
  assign lastCol   = (col == CW'(DIM - 1));
  assign lastRow   = (row == CW'(DIM - 1));

  // The first element of a frame uses the live mode pin; the rest use the latched copy.
  assign modeEff = firstElem ? pool_mode_e'(mode) : modeLat;

  pool_combine #(
    .BITS   (BITS),
    .POOL   (POOL),
    .SIGNED (SIGNED)
  ) u_combine (
    .mode     (modeEff),
    .init     (firstWin),
    .acc      (partBuf[idx]),
    .din      (in_data),
    .acc_next (accNext)
  );

  always_comb begin
    result = accNext[W-1:0];
    if (modeEff == POOL_AVG) begin
      if (SIGNED != 0) begin
        result = W'($signed(accNext) >>> SH);
      end else begin
        result = W'(accNext >> SH);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row       <= '0;
      col       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      modeLat   <= POOL_MAX;
    end else if (clear) begin
      row       <= '0;
      col       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (inXfer) begin
        if (firstElem) begin
          modeLat <= pool_mode_e'(mode);
        end
        if (lastCol) begin
          col <= '0;
          row <= lastRow ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (lastWin) begin
          out_valid <= 1'b1;
          out_data  <= result;
          out_last  <= lastRow && lastCol;
        end
      end
    end
  end

  // Window partials live only in this row-wide buffer; a restarted frame reloads on its first window element.
  always_ff @(posedge clk) begin
    if (inXfer && !clear) begin
      partBuf[idx] <= accNext;
    end
  end

endmodule

// File: tb/tb_maxpool_stream.sv
// tb/tb_maxpool_stream.sv - scoreboard bench for maxpool_stream, unsigned and signed instances
module tb_maxpool_stream;

  localparam int W = 16;

  typedef logic [W-1:0] frame_t [16];
  typedef logic [W-1:0] exp_t [4];
  typedef struct {
    logic [W-1:0] data;
    logic         last;
    int           cyc;
  } exp_s;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mode = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] in_data = '0;

  logic         inReadyU, outValidU, outLastU;
  logic [W-1:0] outDataU;
  logic         inReadyS, outValidS, outLastS;
  logic [W-1:0] outDataS;

  exp_s qU[$];
  exp_s qS[$];
  int   checks = 0;
  int   errors = 0;
  int   pCyc = 0;

  frame_t fA, fB, f9;
  exp_t   eMaxA, eAvgA, eMaxBU, eMaxBS, eAvgBU, eAvgBS, e9;

  maxpool_stream #(.BITS(8), .DIM(4), .POOL(2), .SIGNED(0)) dutU (
    .clk(clk), .rst_n(rst_n), .mode(mode), .clear(clear),
    .in_valid(in_valid), .in_ready(inReadyU), .in_data(in_data),
    .out_valid(outValidU), .out_ready(out_ready), .out_data(outDataU), .out_last(outLastU)
  );

  maxpool_stream #(.BITS(8), .DIM(4), .POOL(2), .SIGNED(1)) dutS (
    .clk(clk), .rst_n(rst_n), .mode(mode), .clear(clear),
    .in_valid(in_valid), .in_ready(inReadyS), .in_data(in_data),
    .out_valid(outValidS), .out_ready(out_ready), .out_data(outDataS), .out_last(outLastS)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pCyc <= pCyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monU
    exp_s e;
    if (rst_n && !clear && outValidU) begin
      if (out_ready) begin
        if (qU.size() == 0) begin
          checks++; errors++;
          $display("FAIL u_unexpected_output: actual=%0h required=none", outDataU);
        end else begin
          e = qU.pop_front();
          chk("u_data", 32'(outDataU), 32'(e.data));
          chk("u_last", 32'(outLastU), 32'(e.last));
          if (e.cyc >= 0) chk("u_latency", 32'(pCyc), 32'(e.cyc));
        end
      end else if (qU.size() > 0) begin
        chk("u_stall_data", 32'(outDataU), 32'(qU[0].data));
        chk("u_stall_in_ready", 32'(inReadyU), 32'(0));
      end
    end
  end

  always @(negedge clk) begin : monS
    exp_s e;
    if (rst_n && !clear && outValidS) begin
      if (out_ready) begin
        if (qS.size() == 0) begin
          checks++; errors++;
          $display("FAIL s_unexpected_output: actual=%0h required=none", outDataS);
        end else begin
          e = qS.pop_front();
          chk("s_data", 32'(outDataS), 32'(e.data));
          chk("s_last", 32'(outLastS), 32'(e.last));
          if (e.cyc >= 0) chk("s_latency", 32'(pCyc), 32'(e.cyc));
        end
      end else if (qS.size() > 0) begin
        chk("s_stall_data", 32'(outDataS), 32'(qS[0].data));
        chk("s_stall_in_ready", 32'(inReadyS), 32'(0));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the element's transfer edge.
  task automatic sendElem(input logic [W-1:0] v);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    while (!inReadyU && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!inReadyU) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: actual=0 required=1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input frame_t f, input logic m, input int n, input bit doPush,
                           input exp_t eu, input exp_t es, input bit latChk);
    for (int i = 0; i < n; i++) begin
      mode = (i == 0) ? m : ~m;
      sendElem(f[i]);
      if (doPush && ((i / 4) % 2 == 1) && ((i % 4) % 2 == 1)) begin
        int k = ((i / 4) / 2) * 2 + (i % 4) / 2;
        qU.push_back('{eu[k], (i == 15), latChk ? pCyc : -1});
        qS.push_back('{es[k], (i == 15), latChk ? pCyc : -1});
      end
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((qU.size() != 0 || qS.size() != 0) && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (qU.size() != 0 || qS.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: actual=%0d,%0d pending required=0", qU.size(), qS.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      fA[i] = W'(i);
      f9[i] = 16'd9;
    end
    fB = '{16'hFFFD, 16'hFFFF, 16'h8000, 16'h0001,
           16'hFFF9, 16'hFFFE, 16'h0001, 16'h0001,
           16'h0001, 16'h0002, 16'h0009, 16'h0009,
           16'h0003, 16'h0004, 16'h0009, 16'h0009};
    eMaxA  = '{16'd5, 16'd7, 16'd13, 16'd15};
    eAvgA  = '{16'd2, 16'd4, 16'd10, 16'd12};
    eMaxBU = '{16'hFFFF, 16'h8000, 16'h0004, 16'h0009};
    eMaxBS = '{16'hFFFF, 16'h0001, 16'h0004, 16'h0009};
    eAvgBU = '{16'hFFFC, 16'h2000, 16'h0002, 16'h0009};
    eAvgBS = '{16'hFFFC, 16'hE000, 16'h0002, 16'h0009};
    e9     = '{16'd9, 16'd9, 16'd9, 16'd9};

    #12 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready_u",  32'(inReadyU),  32'(1));
    chk("rst_out_valid_u", 32'(outValidU), 32'(0));
    chk("rst_out_data_u",  32'(outDataU),  32'(0));
    chk("rst_out_last_u",  32'(outLastU),  32'(0));
    chk("rst_in_ready_s",  32'(inReadyS),  32'(1));
    chk("rst_out_valid_s", 32'(outValidS), 32'(0));
    @(posedge clk);
    #1;

    // Back-to-back frames; mode pin flips after element 0 to exercise the latch.
    sendFrame(fA, 1'b0, 16, 1'b1, eMaxA,  eMaxA,  1'b1);
    sendFrame(fA, 1'b1, 16, 1'b1, eAvgA,  eAvgA,  1'b1);
    sendFrame(fB, 1'b0, 16, 1'b1, eMaxBU, eMaxBS, 1'b1);
    sendFrame(fB, 1'b1, 16, 1'b1, eAvgBU, eAvgBS, 1'b1);
    in_valid = 1'b0;
    drain();

    // Backpressure: hold out_ready low for 5 cycles once a result is pending.
    fork
      sendFrame(fA, 1'b0, 16, 1'b1, eMaxA, eMaxA, 1'b0);
      begin
        int g = 0;
        do begin
          @(posedge clk);
          #1;
          g++;
        end while (!outValidU && g < 100);
        if (!outValidU) begin
          checks++; errors++;
          $display("FAIL stall_wait_timeout: actual=0 required=1");
        end
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    in_valid = 1'b0;
    drain();

    // Clear mid-frame with a pending output and a competing input transfer.
    out_ready = 1'b0;
    sendFrame(fA, 1'b0, 6, 1'b0, eMaxA, eMaxA, 1'b0);
    clear = 1'b1;
    in_valid = 1'b1;
    in_data = 16'd99;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("clr_out_valid_u", 32'(outValidU), 32'(0));
    chk("clr_out_valid_s", 32'(outValidS), 32'(0));
    @(posedge clk);
    #1;
    sendFrame(f9, 1'b0, 16, 1'b1, e9, e9, 1'b1);
    in_valid = 1'b0;
    drain();

    // Asynchronous reset pulse mid-frame with a pending output.
    out_ready = 1'b0;
    sendFrame(fA, 1'b1, 6, 1'b0, eAvgA, eAvgA, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid_u", 32'(outValidU), 32'(0));
    chk("arst_out_valid_s", 32'(outValidS), 32'(0));
    chk("arst_out_data_u",  32'(outDataU),  32'(0));
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    #1;
    chk("arst_in_ready_u", 32'(inReadyU), 32'(1));
    @(posedge clk);
    #1;
    sendFrame(fA, 1'b1, 16, 1'b1, eAvgA, eAvgA, 1'b1);
    in_valid = 1'b0;
    drain();

    chk("final_queue_u", 32'(qU.size()), 32'(0));
    chk("final_queue_s", 32'(qS.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
